// File: rtl/soc_system_instr_fetch_ctrl_if.sv
// CSR, instruction-memory and instruction-stream signals of the fetch controller.
// master = fetch controller side, slave = CSR host / memory / instruction consumer side.
interface soc_system_instr_fetch_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [1:0]        avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] instr_data;
  logic              instr_valid;
  logic              instr_ready;
  logic              instr_last;
  logic              irq;

  modport master (
    input  avs_address, avs_write, avs_writedata, avs_read, mem_readdata, instr_ready,
    output avs_readdata, mem_address, mem_chipselect, mem_clken, mem_write, mem_byteenable,
    output instr_data, instr_valid, instr_last, irq
  );

  modport slave (
    output avs_address, avs_write, avs_writedata, avs_read, mem_readdata, instr_ready,
    input  avs_readdata, mem_address, mem_chipselect, mem_clken, mem_write, mem_byteenable,
    input  instr_data, instr_valid, instr_last, irq
  );
endinterface

// File: rtl/soc_system_instr_fetch_ctrl.sv
// CSR-started instruction fetcher: start -> instr_valid in 3 cycles, 1 instr/cycle when ready.
// Backpressure: issue throttled so buffered + in-flight words never exceed the 2-entry FIFO.
module soc_system_instr_fetch_ctrl #(
  parameter int         ADDR_W  = 10,
  parameter int         DATA_W  = 32,
  parameter logic [7:0] HALT_OP = 8'hFF
) (
  input logic clk,
  input logic reset_n,
  soc_system_instr_fetch_ctrl_if.master bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc, start_pc;
  logic [ADDR_W:0]   remaining, count;
  logic              irq_en, done, error, halted, rd_pend, rd_last;
  logic [DATA_W-1:0] head_dat, tail_dat;
  logic              head_vld, tail_vld, head_last, tail_last;
  logic [31:0]       readdata;

  logic ctrl_wr, start_req, abort_req, busy, pop, issue, push, push_last, cap_halt;
  logic [1:0] used;

  assign ctrl_wr   = bus.avs_write && (bus.avs_address == 2'd0);
  assign abort_req = ctrl_wr && bus.avs_writedata[1];
  assign start_req = ctrl_wr && bus.avs_writedata[0] && !bus.avs_writedata[1];
  assign busy      = (state == S_FETCH) || (state == S_DRAIN);
  assign pop       = head_vld && bus.instr_ready;
  assign used      = 2'(head_vld) + 2'(tail_vld) + 2'(rd_pend);
  // A word leaving the head this cycle frees a slot, so the FIFO can stream 1/cycle.
  assign issue     = (state == S_FETCH) && !halted && (remaining != '0) &&
                     (used < (2'd2 + 2'(pop)));
  assign cap_halt  = bus.mem_readdata[31:24] == HALT_OP;
  assign push      = rd_pend && !halted;
  assign push_last = rd_last || cap_halt;

  wire unused_wdata = &{1'b0, bus.avs_writedata[31:ADDR_W+1]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      pc <= '0; start_pc <= '0; remaining <= '0; count <= '0;
      irq_en <= 1'b0; done <= 1'b0; error <= 1'b0; halted <= 1'b0;
      rd_pend <= 1'b0; rd_last <= 1'b0;
      head_dat <= '0; tail_dat <= '0;
      head_vld <= 1'b0; tail_vld <= 1'b0; head_last <= 1'b0; tail_last <= 1'b0;
      readdata <= '0;
    end else begin
      if (bus.avs_write) begin
        case (bus.avs_address)
          2'd0: irq_en <= bus.avs_writedata[2];
          2'd1: begin
            if (bus.avs_writedata[1]) done  <= 1'b0;
            if (bus.avs_writedata[2]) error <= 1'b0;
          end
          2'd2: start_pc <= bus.avs_writedata[ADDR_W-1:0];
          default: count <= bus.avs_writedata[ADDR_W:0];
        endcase
      end

      if (bus.avs_read) begin
        case (bus.avs_address)
          2'd0:    readdata <= {29'd0, irq_en, 2'b00};
          2'd1:    readdata <= {29'd0, error, done, busy};
          2'd2:    readdata <= 32'(start_pc);
          default: readdata <= 32'(pc);
        endcase
      end

      rd_pend <= issue;
      rd_last <= issue && (remaining == REM_ONE);
      if (issue) begin
        pc        <= pc + ADDR_W'(1);
        remaining <= remaining - REM_ONE;
      end

      if (push) begin
        if (!head_vld || (pop && !tail_vld)) begin
          head_dat <= bus.mem_readdata; head_last <= push_last; head_vld <= 1'b1;
        end else if (pop) begin
          head_dat <= tail_dat; head_last <= tail_last;
          tail_dat <= bus.mem_readdata; tail_last <= push_last;
        end else begin
          tail_dat <= bus.mem_readdata; tail_last <= push_last; tail_vld <= 1'b1;
        end
      end else if (pop) begin
        if (tail_vld) begin
          head_dat <= tail_dat; head_last <= tail_last; tail_vld <= 1'b0;
        end else begin
          head_vld <= 1'b0;
        end
      end
      // Words read after a halt opcode are already in flight; they are dropped on arrival.
      if (push && cap_halt) halted <= 1'b1;

      case (state)
        S_FETCH: if ((issue && remaining == REM_ONE) || (push && cap_halt)) state <= S_DRAIN;
        S_DRAIN: if (pop && head_last) begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        default: ;
      endcase

      if (abort_req) begin
        state <= S_IDLE; error <= 1'b1; halted <= 1'b0;
        head_vld <= 1'b0; tail_vld <= 1'b0; rd_pend <= 1'b0;
      end else if (start_req) begin
        if (busy) begin
          error <= 1'b1;
        end else begin
          pc <= start_pc; remaining <= count; halted <= 1'b0;
          head_vld <= 1'b0; tail_vld <= 1'b0; rd_pend <= 1'b0;
          done  <= (count == '0);
          state <= (count == '0) ? S_DONE : S_FETCH;
        end
      end
    end
  end

  assign bus.avs_readdata   = readdata;
  assign bus.mem_address    = pc;
  assign bus.mem_chipselect = issue;
  assign bus.mem_clken      = issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;
  assign bus.instr_data     = head_dat;
  assign bus.instr_valid    = head_vld;
  assign bus.instr_last     = head_vld && head_last;
  assign bus.irq            = done && irq_en;
endmodule

// File: doc/soc_system_instr_fetch_ctrl.md
SOC_SYSTEM_INSTR_FETCH_CTRL -- requirements
Module: soc_system_instr_fetch_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, instruction-memory word-address width; DATA_W, default 32, instruction width; HALT_OP, default 8'hFF, opcode in instr[31:24] that terminates a program.
REQ-002 SHALL have the following ports, clock and reset first:
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- avs_address  in  2  CSR word select.
- avs_write  in  1  CSR write strobe.
- avs_writedata  in  32  CSR write data.
- avs_read  in  1  CSR read strobe.
- avs_readdata  out  32  CSR read data, registered, valid the cycle after avs_read.
- mem_address  out  ADDR_W  instruction-memory port-2 word address.
- mem_chipselect  out  1  port-2 select.
- mem_clken  out  1  port-2 clock enable; 1 only on read-issue cycles.
- mem_write  out  1  constant 0.
- mem_byteenable  out  4  constant 4'hF.
- mem_readdata  in  DATA_W  port-2 read data; 1-cycle latency after issue.
- instr_data  out  DATA_W  fetched instruction.
- instr_valid  out  1  instr_data valid.
- instr_ready  in  1  consumer accepts when valid & ready.
- instr_last  out  1  marks final instruction of the program.
- irq  out  1  level interrupt = done & irq_en.

Function
REQ-003 SHALL decode CSRs: 0 CTRL (bit0 start, write-1 pulse; bit1 abort, write-1 pulse; bit2 irq_en, R/W); 1 STATUS (bit0 busy RO; bit1 done, sticky, write-1-to-clear; bit2 error, sticky, write-1-to-clear); 2 START_PC (R/W, ADDR_W bits); 3 COUNT (write: instruction count, 0..2^ADDR_W; read: current PC).
REQ-004 SHALL implement states IDLE, FETCH, DRAIN, DONE; busy = (state is FETCH or DRAIN).
REQ-005 Start in IDLE or DONE SHALL load PC := START_PC and remaining := COUNT, clear done, and enter FETCH on the next cycle; start while busy SHALL be ignored and set error.
REQ-006 In FETCH, a read SHALL be issued (mem_chipselect = mem_clken = 1, mem_address = PC) only when FIFO occupancy plus outstanding reads < 2 and remaining > 0; each issue SHALL increment PC and decrement remaining.
REQ-007 PC SHALL wrap modulo 2^ADDR_W (e.g. 1023 -> 0 at ADDR_W = 10) without an error.
REQ-008 Read data SHALL be captured into a 2-entry FIFO the cycle after issue; instr_data/instr_valid SHALL come from the FIFO head register.
REQ-009 Latency: start written at cycle T -> first issue at T+1 -> data captured at T+2 -> instr_valid = 1 at T+3.
REQ-010 With continuous instr_ready = 1, throughput SHALL be 1 instruction per cycle after first valid.
REQ-011 A captured word with instr[31:24] == HALT_OP SHALL be delivered with instr_last = 1; issue SHALL stop and any later in-flight word SHALL be discarded.
REQ-012 The word that brings remaining to 0 SHALL be delivered with instr_last = 1.
REQ-013 FETCH -> DRAIN when issue stops; DRAIN -> DONE when the instr_last word is accepted; DONE sets done and remains until the next start.
REQ-014 COUNT = 0 at start SHALL go directly to DONE next cycle with no reads and no instr_valid.
REQ-015 Abort SHALL flush the FIFO, drop outstanding reads, deassert instr_valid next cycle, set error, and go to IDLE; start and abort in the same write SHALL resolve as abort.
REQ-016 instr_data SHALL remain stable while instr_valid & !instr_ready.
REQ-017 CSR writes to START_PC/COUNT while busy SHALL update the register but not affect the running program.

Reset
REQ-018 On reset_n = 0 at a clk edge, the block SHALL set: state IDLE; PC, remaining, FIFO, START_PC, COUNT, irq_en, done, error = 0; instr_valid, instr_last, irq, mem_chipselect, mem_clken = 0; avs_readdata = 0.
REQ-019 Reset mid-program SHALL discard all in-flight data; no instr_valid in the cycle following release.

Verification
REQ-020 START_PC=5, COUNT=3, ready=1, mem[5..7]=A,B,C -> instr_valid at T+3; A,B,C on consecutive cycles, last on C; done=1 -> irq=1 when irq_en=1.
REQ-021 START_PC=1022, COUNT=4 -> addresses 1022,1023,0,1 issued in order; no error.
REQ-022 mem[10]=32'hFF000000, START_PC=8, COUNT=6 -> 3 words delivered, last on the 3rd; address 11 never delivered; done=1.
REQ-023 instr_ready held 0 for 5 cycles mid-program -> at most 2 reads outstanding or buffered; no loss or duplication; instr_data stable.
REQ-024 Abort in FETCH -> instr_valid=0 next cycle, error=1, busy=0; start while busy -> error=1, sequence unaffected.
REQ-025 COUNT=0 start -> done=1 after 1 cycle, mem_clken never asserted; reset_n=0 mid-program -> all outputs at reset values.
